// File: rtl/btn_pkg.sv
// Shared encodings and defaults for the push-button conditioning path.
package btn_pkg;

  localparam logic [1:0] STABLE_LOW  = 2'b00;
  localparam logic [1:0] WAIT_HIGH   = 2'b01;
  localparam logic [1:0] STABLE_HIGH = 2'b11;
  localparam logic [1:0] WAIT_LOW    = 2'b10;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; synchronous active-high reset to 0.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw push-button pin into a clean level plus one-cycle press/release pulses.
import btn_pkg::*;

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit BTN_ACTIVE_LOW  = 1'b0,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_in;
  logic             sync2;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, rise_nxt, fall_nxt;

  // Polarity is normalised before the synchroniser so reset-to-0 means "released".
  assign btn_in = btn_raw ^ BTN_ACTIVE_LOW;

  sync_2ff #(.W(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync2)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = btn_level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (sync2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          state_nxt = STABLE_LOW;
        end else if (cnt == CNT_MAX) begin
          state_nxt = STABLE_HIGH;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!sync2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          state_nxt = STABLE_HIGH;
        end else if (cnt == CNT_MAX) begin
          state_nxt = STABLE_LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = STABLE_LOW;
    endcase
  end

  // busy is registered from the next state so it tracks the WAIT states exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STABLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= level_nxt;
      btn_rise  <= rise_nxt;
      btn_fall  <= fall_nxt;
      busy      <= state_nxt[1] ^ state_nxt[0];
    end
  end

endmodule
